// File: rtl/data_bus_bridge.sv
// data_bus_bridge
//   Converts one core load/store into one or two aligned word transactions on a
//   req/ack memory bus. Accesses that straddle a word boundary are split into a
//   low word and a following high word; read data is returned right-justified
//   and zero-filled (sign extension is the core's job).
//
//   Ports
//     clock, reset           : clock, asynchronous active-low reset
//     core_address/width/    : core access (width 0 byte, 1 half, 2 word, 3 none)
//       wdata/read/write
//     core_rdata             : load result, valid while in DONE
//     core_stall             : high while a request is pending and not yet done
//     bus_error              : one-cycle pulse in DONE on timeout/illegal request
//     mem_req/we/addr/be/    : word-wide bus request side
//       wdata
//     mem_ack, mem_rdata     : bus completion and read data
//
//   state | meaning
//   IDLE  | waiting for a core request, latches it
//   BUS1  | first (or only) word transaction outstanding
//   BUS2  | second word of a split access outstanding
//   DONE  | result/error presented, core retires at this edge
module data_bus_bridge #(
   parameter int TIMEOUT_CYCLES   = 255,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] core_address,
   input  logic [1:0]  core_width,
   input  logic [31:0] core_wdata,
   input  logic        core_read,
   input  logic        core_write,
   output logic [31:0] core_rdata,
   output logic        core_stall,
   output logic        bus_error,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   // The wait counter only has to reach TIMEOUT_CYCLES-1 before the timeout fires.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, BUS1, BUS2, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       off_q;
   logic [31:0]      mask_q;
   logic             we_q;
   logic             split_q;
   logic [3:0]       be_hi_q;
   logic [31:0]      wd_hi_q;
   logic [31:0]      lo_q;

   logic             request;
   logic             in_split;
   logic [1:0]       in_off;
   logic [3:0]       in_base;
   logic [31:0]      in_mask;
   logic [7:0]       in_be;
   logic [63:0]      in_wd;
   logic [63:0]      rd_word;
   logic [63:0]      rd_shift;
   logic [31:0]      rd_val;

   assign request    = (core_read | core_write) & (core_width != 2'd3);
   assign core_stall = request & (state != DONE);

   // Byte enables and write data are formed over a two-word window: the lower
   // word is the first transaction, the upper word the split-off second one.
   always_comb begin
      in_off  = core_address[1:0];
      in_base = 4'b1111;
      in_mask = 32'hFFFF_FFFF;
      case (core_width)
         2'd0: begin
            in_base = 4'b0001;
            in_mask = 32'h0000_00FF;
         end
         2'd1: begin
            in_base = 4'b0011;
            in_mask = 32'h0000_FFFF;
         end
         default: ;
      endcase
      in_split = ((core_width == 2'd1) && (in_off == 2'd3)) ||
                 ((core_width == 2'd2) && (in_off != 2'd0));
      in_be    = {4'b0000, in_base} << in_off;
      in_wd    = {32'h0000_0000, core_wdata} << {in_off, 3'b000};
      rd_word  = (state == BUS2) ? {mem_rdata, lo_q} : {32'h0000_0000, mem_rdata};
      rd_shift = rd_word >> {off_q, 3'b000};
      rd_val   = rd_shift[31:0] & mask_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         off_q      <= '0;
         mask_q     <= '0;
         we_q       <= 1'b0;
         split_q    <= 1'b0;
         be_hi_q    <= '0;
         wd_hi_q    <= '0;
         lo_q       <= '0;
         core_rdata <= '0;
         bus_error  <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_be     <= '0;
         mem_wdata  <= '0;
      end else begin
         // DONE lasts exactly one cycle, so these defaults make both a pulse.
         bus_error  <= 1'b0;
         core_rdata <= '0;
         case (state)
            IDLE: begin
               if (request) begin
                  off_q   <= in_off;
                  mask_q  <= in_mask;
                  we_q    <= core_write;
                  split_q <= in_split;
                  be_hi_q <= in_be[7:4];
                  wd_hi_q <= in_wd[63:32];
                  cnt     <= '0;
                  if ((core_read && core_write) || (in_split && !ALLOW_MISALIGNED)) begin
                     bus_error <= 1'b1;
                     state     <= DONE;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= core_write;
                     mem_addr  <= {core_address[31:2], 2'b00};
                     mem_be    <= in_be[3:0];
                     mem_wdata <= in_wd[31:0];
                     state     <= BUS1;
                  end
               end
            end
            BUS1, BUS2: begin
               if (mem_ack) begin
                  cnt <= '0;
                  if (state == BUS1) lo_q <= mem_rdata;
                  if ((state == BUS1) && split_q) begin
                     mem_addr  <= mem_addr + 32'd4;
                     mem_be    <= be_hi_q;
                     mem_wdata <= wd_hi_q;
                     state     <= BUS2;
                  end else begin
                     mem_req    <= 1'b0;
                     mem_we     <= 1'b0;
                     mem_be     <= '0;
                     mem_wdata  <= '0;
                     core_rdata <= we_q ? 32'h0000_0000 : rd_val;
                     state      <= DONE;
                  end
               end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                  // Abandon the access; an unissued second half is dropped too.
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_be    <= '0;
                  mem_wdata <= '0;
                  bus_error <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_bus_bridge.sv
module tb_data_bus_bridge;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] core_address = '0;
   logic [1:0]  core_width = '0;
   logic [31:0] core_wdata = '0;
   logic        core_read = 1'b0;
   logic        core_write = 1'b0;
   logic [31:0] core_rdata;
   logic        core_stall;
   logic        bus_error;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   data_bus_bridge #(.TIMEOUT_CYCLES(4), .ALLOW_MISALIGNED(1'b1)) dut (
      .clock(clock), .reset(reset),
      .core_address(core_address), .core_width(core_width), .core_wdata(core_wdata),
      .core_read(core_read), .core_write(core_write),
      .core_rdata(core_rdata), .core_stall(core_stall), .bus_error(bus_error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } res_t;

   txn_t txq[$];
   res_t resq[$];

   task automatic push_txn(input logic [31:0] addr, input logic [3:0] be, input logic we,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
      txn_t t;
      t.addr = addr; t.be = be; t.we = we; t.wdata = wdata; t.rdata = rdata; t.delay = delay;
      txq.push_back(t);
   endtask

   task automatic push_res(input logic [31:0] rdata, input logic err, input int lat);
      res_t r;
      r.rdata = rdata; r.err = err; r.lat = lat;
      resq.push_back(r);
   endtask

   // Drives one core access starting at a falling edge and plays the memory
   // side from the transaction queue until the core is released.
   task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [1:0] w, input logic [31:0] wd, input string name,
                             output int req_cycles);
      txn_t cur;
      res_t r;
      bit   have = 0;
      bit   done = 0;
      int   waited = 0;
      int   cyc = 0;
      req_cycles = 0;
      core_read = rd; core_write = wr; core_address = addr; core_width = w; core_wdata = wd;
      while (!done && cyc < 40) begin
         #1;
         mem_ack = 1'b0;
         mem_rdata = $urandom;
         if (core_stall === 1'b0) begin
            done = 1;
            checks++;
            if (resq.size() == 0) begin
               errors++;
               $display("FAIL %s result: DONE reached with no expected result queued", name);
            end else begin
               r = resq.pop_front();
               if (core_rdata !== r.rdata || bus_error !== r.err || cyc != r.lat) begin
                  errors++;
                  $display("FAIL %s result: got rdata=%h err=%b lat=%0d, want rdata=%h err=%b lat=%0d",
                           name, core_rdata, bus_error, cyc, r.rdata, r.err, r.lat);
               end
            end
            checks++;
            if (txq.size() != 0) begin
               errors++;
               $display("FAIL %s txns: got %0d transactions not issued, want 0", name, txq.size());
               txq.delete();
            end
            core_read = 1'b0; core_write = 1'b0;
            core_address = $urandom; core_wdata = $urandom;
         end else begin
            if (mem_req === 1'b1) begin
               req_cycles++;
               if (!have) begin
                  checks++;
                  if (txq.size() == 0) begin
                     errors++;
                     $display("FAIL %s unexpected request: got addr=%h be=%b, want none",
                              name, mem_addr, mem_be);
                     cur.addr = mem_addr; cur.be = mem_be; cur.we = mem_we;
                     cur.wdata = mem_wdata; cur.rdata = '0; cur.delay = 0;
                  end else begin
                     cur = txq.pop_front();
                     if (mem_addr !== cur.addr || mem_be !== cur.be || mem_we !== cur.we ||
                         (cur.we && mem_wdata !== cur.wdata)) begin
                        errors++;
                        $display("FAIL %s bus txn: got addr=%h be=%b we=%b wdata=%h, want addr=%h be=%b we=%b wdata=%h",
                                 name, mem_addr, mem_be, mem_we, mem_wdata,
                                 cur.addr, cur.be, cur.we, cur.wdata);
                     end
                  end
                  have = 1;
                  waited = 0;
               end
               if (waited >= cur.delay) begin
                  mem_ack = 1'b1;
                  mem_rdata = cur.rdata;
                  have = 0;
               end else begin
                  waited++;
               end
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
         end
      end
      mem_ack = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s completion: got stall still high after %0d cycles, want release", name, cyc);
         core_read = 1'b0; core_write = 1'b0;
         txq.delete(); resq.delete();
      end
      @(posedge clock);
      @(negedge clock);
      #1;
      checks++;
      if (bus_error !== 1'b0 || core_stall !== 1'b0 || mem_req !== 1'b0 || core_rdata !== 32'h0) begin
         errors++;
         $display("FAIL %s after done: got err=%b stall=%b req=%b rdata=%h, want all 0",
                  name, bus_error, core_stall, mem_req, core_rdata);
      end
      @(negedge clock);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      mem_ack = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, core_rdata, bus_error, core_stall} !== '0) begin
         errors++;
         $display("FAIL reset state: got req=%b we=%b addr=%h be=%b wdata=%h rdata=%h err=%b stall=%b, want all 0",
                  mem_req, mem_we, mem_addr, mem_be, mem_wdata, core_rdata, bus_error, core_stall);
      end
      @(negedge clock);
      mem_ack = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      #1;
      checks++;
      if (mem_req !== 1'b0 || core_stall !== 1'b0 || bus_error !== 1'b0) begin
         errors++;
         $display("FAIL reset release: got req=%b stall=%b err=%b, want 0 0 0", mem_req, core_stall, bus_error);
      end
      @(negedge clock);
   endtask

   task automatic test_aligned();
      int rc;
      push_txn(32'h100, 4'hF, 1'b0, 32'h0, 32'hDEADBEEF, 0);
      push_res(32'hDEADBEEF, 1'b0, 2);
      run_access(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, "lw_aligned", rc);
      push_txn(32'h200, 4'b1000, 1'b1, 32'hA500_0000, 32'h0, 0);
      push_res(32'h0, 1'b0, 2);
      run_access(1'b0, 1'b1, 32'h203, 2'd0, 32'h0000_00A5, "sb_lane3", rc);
      push_txn(32'h400, 4'b1100, 1'b0, 32'h0, 32'hCAFE_F00D, 2);
      push_res(32'h0000_CAFE, 1'b0, 4);
      run_access(1'b1, 1'b0, 32'h402, 2'd1, 32'h0, "lhu_wait2", rc);
      push_txn(32'h300, 4'b1000, 1'b0, 32'h0, 32'h8011_2233, 0);
      push_res(32'h0000_0080, 1'b0, 2);
      run_access(1'b1, 1'b0, 32'h303, 2'd0, 32'h0, "lb_zero_fill", rc);
   endtask

   task automatic test_split();
      int rc;
      push_txn(32'h0FC, 4'b1100, 1'b0, 32'h0, 32'hDDCC_BBAA, 0);
      push_txn(32'h100, 4'b0011, 1'b0, 32'h0, 32'h4433_2211, 0);
      push_res(32'h2211_DDCC, 1'b0, 3);
      run_access(1'b1, 1'b0, 32'h0FE, 2'd2, 32'h0, "lw_split", rc);
      push_txn(32'hFFFF_FFFC, 4'b1000, 1'b1, 32'hEF00_0000, 32'h0, 0);
      push_txn(32'h0000_0000, 4'b0001, 1'b1, 32'h0000_00BE, 32'h0, 0);
      push_res(32'h0, 1'b0, 3);
      run_access(1'b0, 1'b1, 32'hFFFF_FFFF, 2'd1, 32'h0000_BEEF, "sh_wrap", rc);
      push_txn(32'h500, 4'b1110, 1'b1, 32'h3456_7800, 32'h0, 1);
      push_txn(32'h504, 4'b0001, 1'b1, 32'h0000_0012, 32'h0, 3);
      push_res(32'h0, 1'b0, 7);
      run_access(1'b0, 1'b1, 32'h501, 2'd2, 32'h1234_5678, "sw_split_wait", rc);
   endtask

   task automatic test_timeout();
      int rc;
      push_txn(32'h600, 4'hF, 1'b0, 32'h0, 32'h0, 1000);
      push_res(32'h0, 1'b1, 5);
      run_access(1'b1, 1'b0, 32'h600, 2'd2, 32'h0, "timeout_word", rc);
      checks++;
      if (rc != 4) begin
         errors++;
         $display("FAIL timeout req cycles: got %0d, want 4", rc);
      end
      // Only the first half is expected; a second request would be flagged.
      push_txn(32'h7FC, 4'b1100, 1'b0, 32'h0, 32'h0, 1000);
      push_res(32'h0, 1'b1, 5);
      run_access(1'b1, 1'b0, 32'h7FE, 2'd2, 32'h0, "timeout_split", rc);
   endtask

   task automatic test_illegal();
      int rc;
      push_res(32'h0, 1'b1, 1);
      run_access(1'b1, 1'b1, 32'h800, 2'd2, 32'h1111_2222, "read_and_write", rc);
      checks++;
      if (rc != 0) begin
         errors++;
         $display("FAIL illegal bus access: got %0d request cycles, want 0", rc);
      end
      core_read = 1'b1; core_width = 2'd3; core_address = 32'h900;
      repeat (3) begin
         #1;
         checks++;
         if (core_stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL width3 no access: got stall=%b req=%b, want 0 0", core_stall, mem_req);
         end
         @(negedge clock);
      end
      core_read = 1'b0; core_width = 2'd0;
   endtask

   task automatic test_back_to_back();
      int rc;
      for (int i = 0; i < 6; i++) begin
         logic [31:0] base, word, exp;
         logic [1:0]  off;
         base = $urandom & 32'hFFFF_FFF0;
         word = $urandom;
         off  = 2'($urandom_range(0, 3));
         case (off)
            2'd0: exp = {24'h0, word[7:0]};
            2'd1: exp = {24'h0, word[15:8]};
            2'd2: exp = {24'h0, word[23:16]};
            default: exp = {24'h0, word[31:24]};
         endcase
         push_txn(base, 4'b0001 << off, 1'b0, 32'h0, word, i % 2);
         push_res(exp, 1'b0, 2 + (i % 2));
         run_access(1'b1, 1'b0, base | {30'h0, off}, 2'd0, 32'h0, "b2b_lbu", rc);
      end
   endtask

   task automatic test_reset_mid();
      int rc;
      core_read = 1'b1; core_width = 2'd2; core_address = 32'hA0E;
      @(posedge clock); @(negedge clock); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hA0C || mem_be !== 4'b1100) begin
         errors++;
         $display("FAIL midreset first half: got req=%b addr=%h be=%b, want 1 00000a0c 1100",
                  mem_req, mem_addr, mem_be);
      end
      mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clock); @(negedge clock); #1;
      mem_ack = 1'b0;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hA10 || mem_be !== 4'b0011) begin
         errors++;
         $display("FAIL midreset second half: got req=%b addr=%h be=%b, want 1 00000a10 0011",
                  mem_req, mem_addr, mem_be);
      end
      @(posedge clock); @(negedge clock);
      reset = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || bus_error !== 1'b0 || core_rdata !== 32'h0) begin
         errors++;
         $display("FAIL midreset drop: got req=%b err=%b rdata=%h, want 0 0 0", mem_req, bus_error, core_rdata);
      end
      core_read = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clock); @(negedge clock);
      mem_ack = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || core_stall !== 1'b0 || bus_error !== 1'b0 || core_rdata !== 32'h0) begin
         errors++;
         $display("FAIL late ack: got req=%b stall=%b err=%b rdata=%h, want 0 0 0 0",
                  mem_req, core_stall, bus_error, core_rdata);
      end
      @(negedge clock);
      push_txn(32'h700, 4'b0010, 1'b0, 32'h0, 32'h1122_3344, 0);
      push_res(32'h0000_0033, 1'b0, 2);
      run_access(1'b1, 1'b0, 32'h701, 2'd0, 32'h0, "lbu_after_reset", rc);
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_split();
      test_timeout();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running at 200000, want finished");
      $fatal(1, "watchdog expired");
   end

endmodule
